// File: rtl/call_stack.sv
// rtl/call_stack.sv - hardware return-address stack with registered top-of-stack
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   push            push request; push_addr is written as the new top
//   pop             pop request; the entry below the top becomes the new top
//   push_addr       return address written on push
//   flush           discard all entries; push/pop in the same cycle are ignored
//   err_clear       clear both sticky error flags (a same-cycle error wins)
//   top_addr        registered top-of-stack entry, 0 when empty
//   count           registered number of valid entries, 0..DEPTH
//   empty           count == 0
//   full            count == DEPTH
//   stack_overflow  sticky: push attempted while full
//   stack_underflow sticky: pop attempted while empty

module call_stack #(
    parameter  int DEPTH = 8,
    parameter  int AW    = 12,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic          flush,
    input  logic          err_clear,
    output logic [AW-1:0] top_addr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          stack_overflow,
    output logic          stack_underflow
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] entry [DEPTH];

    logic [CW-1:0] count_m1;
    logic [CW-1:0] count_m2;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;
    logic          do_replace;
    logic          mem_we;
    logic          ovf_set;
    logic          unf_set;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_comb begin
        count_m1   = count - CW'(1);
        count_m2   = count - CW'(2);
        // A push+pop on an empty stack degenerates into a plain push.
        do_replace = !flush && push && pop && !empty;
        do_push    = !flush && push && !do_replace && !full;
        do_pop     = !flush && pop && !push && !empty;
        ovf_set    = !flush && push && !pop && full;
        unf_set    = !flush && pop && !push && empty;
        mem_we     = do_push || do_replace;
        // Replace overwrites the current top; a push writes one above it.
        wr_idx     = do_replace ? count_m1[IW-1:0] : count[IW-1:0];
        // Only consulted when popping from count >= 2.
        rd_idx     = count_m2[IW-1:0];
    end

    // Storage carries no reset: entries above count are never observed.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            entry[wr_idx] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count           <= '0;
            top_addr        <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            stack_overflow  <= ovf_set || (stack_overflow && !err_clear);
            stack_underflow <= unf_set || (stack_underflow && !err_clear);
            if (flush) begin
                count    <= '0;
                top_addr <= '0;
            end else if (do_replace) begin
                top_addr <= push_addr;
            end else if (do_push) begin
                count    <= count + CW'(1);
                top_addr <= push_addr;
            end else if (do_pop) begin
                count    <= count_m1;
                top_addr <= (count_m1 == '0) ? '0 : entry[rd_idx];
            end
        end
    end

endmodule
